mem_align: RTL and testbench



---
 rtl/mem_align_if.sv | 31 +++
 rtl/mem_align.sv | 186 ++++++++++++++++++
 tb/tb_mem_align.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_align_if.sv
// Bus between the memory-stage pipeline/dmem side and the alignment unit.
// Signal names are written from the point of view of mem_align.
interface mem_align_if #(
    parameter int ADDR_WIDTH = 11
);
    logic                  i_valid;
    logic                  i_mem_read;
    logic                  i_mem_write;
    logic [2:0]            i_funct3;
    logic [31:0]           i_addr;
    logic [31:0]           i_wdata;
    logic [31:0]           i_rdata;
    logic                  o_ready;
    logic [ADDR_WIDTH-1:0] o_addr;
    logic [31:0]           o_wdata;
    logic                  o_we;
    logic [3:0]            o_mem_type;
    logic                  o_ld_valid;
    logic [31:0]           o_ld_data;
    logic                  o_illegal;

    modport master (
        output i_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata, i_rdata,
        input  o_ready, o_addr, o_wdata, o_we, o_mem_type, o_ld_valid, o_ld_data, o_illegal
    );

    modport slave (
        input  i_valid, i_mem_read, i_mem_write, i_funct3, i_addr, i_wdata, i_rdata,
        output o_ready, o_addr, o_wdata, o_we, o_mem_type, o_ld_valid, o_ld_data, o_illegal
    );
endinterface

// File: rtl/mem_align.sv
// Load/store alignment unit in front of dmem: byte lanes, lane rotation,
// splitting of misaligned accesses into two word accesses, load merge/extend.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | accepting requests; access driven straight from the inputs
//   SECOND | driving the registered second half of a misaligned access
module mem_align #(
    parameter int DEPTH      = 2048,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH = 32
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    mem_align_if.slave bus
);
    localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } state_t;

    state_t state_q, state_d;

    function automatic logic [DATA_WIDTH-1:0] rotl_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [1:0] n);
        case (n)
            2'd0:    rotl_bytes = d;
            2'd1:    rotl_bytes = {d[23:0], d[31:24]};
            2'd2:    rotl_bytes = {d[15:0], d[31:16]};
            default: rotl_bytes = {d[7:0],  d[31:8]};
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] rotr_bytes(input logic [DATA_WIDTH-1:0] d,
                                                         input logic [1:0] n);
        case (n)
            2'd0:    rotr_bytes = d;
            2'd1:    rotr_bytes = {d[7:0],  d[31:8]};
            2'd2:    rotr_bytes = {d[15:0], d[31:16]};
            default: rotr_bytes = {d[23:0], d[31:24]};
        endcase
    endfunction

    logic [1:0]            off;
    logic [ADDR_WIDTH-1:0] word;
    logic [ADDR_WIDTH-1:0] word_next;
    logic [3:0]            base_mask;
    logic [7:0]            lane_m;
    logic [DATA_WIDTH-1:0] wdata_rot;
    logic                  req;
    logic                  is_wr;
    logic                  illegal;
    logic                  legal_req;
    logic                  split;

    // Second-access and load-return registers
    logic [ADDR_WIDTH-1:0] sec_addr_q;
    logic [3:0]            sec_mask_q;
    logic [DATA_WIDTH-1:0] sec_wdata_q;
    logic                  sec_we_q;
    logic                  sec_ld_q;
    logic [1:0]            ld_off_q;
    logic [2:0]            ld_funct3_q;
    logic                  ld_valid_q;
    logic                  illegal_q;
    logic [DATA_WIDTH-1:0] acc_q;

    logic [DATA_WIDTH-1:0] merged;
    logic [DATA_WIDTH-1:0] aligned_ld;
    logic [DATA_WIDTH-1:0] ext;

    // Address bits above the memory are ignored by design
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.i_addr[31:ADDR_WIDTH+2];

    assign off       = bus.i_addr[1:0];
    assign word      = bus.i_addr[ADDR_WIDTH+1:2];
    assign word_next = (word == LAST_WORD) ? '0 : word + ADDR_WIDTH'(1);
    assign is_wr     = bus.i_mem_write;
    assign wdata_rot = rotl_bytes(bus.i_wdata, off);
    assign lane_m    = {4'b0000, base_mask} << off;

    // Held in reset the bus must stay quiet even if the pipeline presents a request
    assign req       = bus.i_valid && i_reset_n && (state_q == IDLE)
                       && (bus.i_mem_read || bus.i_mem_write);
    assign illegal   = (bus.i_funct3 == 3'b011) || (bus.i_funct3[2:1] == 2'b11)
                       || (is_wr && bus.i_funct3[2]);
    assign legal_req = req && !illegal;
    assign split     = legal_req && (lane_m[7:4] != 4'b0000);

    assign bus.o_ready    = (state_q == IDLE);
    assign bus.o_ld_valid = ld_valid_q;
    assign bus.o_illegal  = illegal_q;

    // Size-based lane mask before shifting by the byte offset
    always_comb begin
        base_mask = 4'b1111;
        case (bus.i_funct3[1:0])
            2'b00:   base_mask = 4'b0001;
            2'b01:   base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
    end

    // Next state and dmem access: first half from inputs, second half from registers
    always_comb begin
        state_d        = state_q;
        bus.o_addr     = '0;
        bus.o_mem_type = 4'b0000;
        bus.o_wdata    = '0;
        bus.o_we       = 1'b0;
        case (state_q)
            IDLE: begin
                if (legal_req) begin
                    bus.o_addr     = word;
                    bus.o_mem_type = lane_m[3:0];
                    bus.o_wdata    = wdata_rot;
                    bus.o_we       = is_wr;
                    if (split) begin
                        state_d = SECOND;
                    end
                end
            end
            SECOND: begin
                bus.o_addr     = sec_addr_q;
                bus.o_mem_type = sec_mask_q;
                bus.o_wdata    = sec_wdata_q;
                bus.o_we       = sec_we_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, split bookkeeping and load-return tracking
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q     <= IDLE;
            sec_addr_q  <= '0;
            sec_mask_q  <= 4'b0000;
            sec_wdata_q <= '0;
            sec_we_q    <= 1'b0;
            sec_ld_q    <= 1'b0;
            ld_off_q    <= 2'b00;
            ld_funct3_q <= 3'b000;
            ld_valid_q  <= 1'b0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
        end else begin
            state_q <= state_d;
            if (split) begin
                sec_addr_q  <= word_next;
                sec_mask_q  <= lane_m[7:4];
                sec_wdata_q <= wdata_rot;
                sec_we_q    <= is_wr;
                sec_ld_q    <= !is_wr;
            end
            if (legal_req && !is_wr) begin
                ld_off_q    <= off;
                ld_funct3_q <= bus.i_funct3;
            end
            ld_valid_q <= (legal_req && !is_wr && !split)
                          || ((state_q == SECOND) && sec_ld_q);
            illegal_q  <= req && illegal;
            // During SECOND the first half's read data is returning; hold it for the merge
            acc_q      <= (state_q == SECOND) ? bus.i_rdata : '0;
        end
    end

    // Merge both halves, rotate back to LSB-justified, then extend
    always_comb begin
        merged     = acc_q | bus.i_rdata;
        aligned_ld = rotr_bytes(merged, ld_off_q);
        ext        = aligned_ld;
        case (ld_funct3_q)
            3'b000:  ext = {{24{aligned_ld[7]}},  aligned_ld[7:0]};
            3'b001:  ext = {{16{aligned_ld[15]}}, aligned_ld[15:0]};
            3'b100:  ext = {24'h000000, aligned_ld[7:0]};
            3'b101:  ext = {16'h0000,   aligned_ld[15:0]};
            default: ext = aligned_ld;
        endcase
        bus.o_ld_data = ld_valid_q ? ext : '0;
    end
endmodule

// File: tb/tb_mem_align.sv
// Bench for mem_align: directed cases plus randomized loads/stores checked
// against a byte-addressed reference memory.
module tb_mem_align;
    localparam int DEPTH  = 2048;
    localparam int AW     = 11;
    localparam int NBYTES = DEPTH * 4;

    logic i_clk     = 1'b0;
    logic i_reset_n = 1'b1;

    mem_align_if #(.ADDR_WIDTH(AW)) bus ();

    mem_align #(.DEPTH(DEPTH)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .bus       (bus)
    );

    always #5 i_clk = ~i_clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] dmem [DEPTH];
    logic [7:0]  ref_mem [NBYTES];

    function automatic logic [31:0] init_word(input int unsigned w);
        return (w * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    // dmem: one-cycle registered read, byte-lane write, disabled lanes read zero
    initial begin
        logic [31:0] cur;
        logic [31:0] rd;
        for (int w = 0; w < DEPTH; w++) dmem[w] = init_word(w);
        bus.i_rdata = 32'h0;
        forever begin
            @(posedge i_clk);
            cur = dmem[bus.o_addr];
            rd  = 32'h0;
            for (int i = 0; i < 4; i++) begin
                if (bus.o_mem_type[i]) rd[8*i +: 8] = cur[8*i +: 8];
                if (bus.o_we && bus.o_mem_type[i]) cur[8*i +: 8] = bus.o_wdata[8*i +: 8];
            end
            dmem[bus.o_addr] = cur;
            bus.i_rdata <= rd;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic legal(input logic wr, input logic [2:0] f3);
        if (wr) return f3 inside {3'b000, 3'b001, 3'b010};
        return f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    endfunction

    // Byte k of the access lands in lane off+k; lanes 4..7 belong to the next word
    function automatic logic [7:0] lanes(input int unsigned a, input logic [2:0] f3);
        logic [7:0] m = 8'h00;
        for (int k = 0; k < int'(size_of(f3)); k++) m[(a % 4) + k] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] wd, input int unsigned off);
        logic [31:0] r = 32'h0;
        for (int k = 0; k < 4; k++) r[8*((off + k) % 4) +: 8] = wd[8*k +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input int unsigned a, input logic [2:0] f3);
        int unsigned n = size_of(f3);
        logic [31:0] v = 32'h0;
        for (int k = 0; k < int'(n); k++) v[8*k +: 8] = ref_mem[(a + k) % NBYTES];
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8*n));
        return v;
    endfunction

    task automatic ref_store(input int unsigned a, input logic [2:0] f3, input logic [31:0] wd);
        for (int k = 0; k < int'(size_of(f3)); k++) ref_mem[(a + k) % NBYTES] = wd[8*k +: 8];
    endtask

    logic        s_ready0, s_we0, s_ready1, s_we1, s_ldv1, s_ill1, s_ldv2;
    logic [3:0]  s_mt0, s_mt1;
    logic [AW-1:0] s_addr0, s_addr1;
    logic [31:0] s_wd0, s_wd1, s_ldd1, s_ldd2;

    // Present one request for one cycle, then watch two more cycles
    task automatic issue(input logic wr, input logic rd, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_mem_write = wr; bus.i_mem_read = rd;
        bus.i_funct3 = f3; bus.i_addr = a; bus.i_wdata = wd;
        #1;
        s_ready0 = bus.o_ready; s_addr0 = bus.o_addr; s_mt0 = bus.o_mem_type;
        s_wd0 = bus.o_wdata; s_we0 = bus.o_we;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        #1;
        s_ready1 = bus.o_ready; s_addr1 = bus.o_addr; s_mt1 = bus.o_mem_type;
        s_wd1 = bus.o_wdata; s_we1 = bus.o_we; s_ldv1 = bus.o_ld_valid;
        s_ldd1 = bus.o_ld_data; s_ill1 = bus.o_illegal;
        @(negedge i_clk);
        #1;
        s_ldv2 = bus.o_ld_valid; s_ldd2 = bus.o_ld_data;
    endtask

    task automatic check_txn(input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd);
        int unsigned ab  = a % NBYTES;
        int unsigned w0  = ab / 4;
        int unsigned w1  = (w0 + 1) % DEPTH;
        logic [7:0]  m   = lanes(ab, f3);
        logic        lg  = legal(wr, f3);
        logic        mis = lg && (m[7:4] != 4'h0);
        logic        v1  = lg && !wr && !mis;
        logic        v2  = lg && !wr && mis;
        logic [31:0] exp_ld = ref_load(ab, f3);
        logic [31:0] exp_wd = lane_data(wd, ab % 4);
        issue(wr, !wr, f3, a, wd);
        chk("ready_n", {31'h0, s_ready0}, 32'h1);
        chk("lanes_n", {28'h0, s_mt0}, lg ? {28'h0, m[3:0]} : 32'h0);
        chk("we_n", {31'h0, s_we0}, {31'h0, lg && wr});
        if (lg) chk("addr_n", {21'h0, s_addr0}, w0);
        if (lg && wr) chk("wdata_n", s_wd0, exp_wd);
        chk("ready_n1", {31'h0, s_ready1}, {31'h0, !mis});
        chk("illegal_n1", {31'h0, s_ill1}, {31'h0, !lg});
        chk("we_n1", {31'h0, s_we1}, {31'h0, mis && wr});
        if (mis) begin
            chk("addr_n1", {21'h0, s_addr1}, w1);
            chk("lanes_n1", {28'h0, s_mt1}, {28'h0, m[7:4]});
            if (wr) chk("wdata_n1", s_wd1, exp_wd);
        end
        chk("ldv_n1", {31'h0, s_ldv1}, {31'h0, v1});
        chk("ldv_n2", {31'h0, s_ldv2}, {31'h0, v2});
        if (v1) chk("ldata_n1", s_ldd1, exp_ld);
        if (v2) chk("ldata_n2", s_ldd2, exp_ld);
        if (lg && wr) ref_store(ab, f3, wd);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ready"}, {31'h0, bus.o_ready}, 32'h1);
        chk({tag, "_we"}, {31'h0, bus.o_we}, 32'h0);
        chk({tag, "_lanes"}, {28'h0, bus.o_mem_type}, 32'h0);
        chk({tag, "_addr"}, {21'h0, bus.o_addr}, 32'h0);
        chk({tag, "_wdata"}, bus.o_wdata, 32'h0);
        chk({tag, "_ldv"}, {31'h0, bus.o_ld_valid}, 32'h0);
        chk({tag, "_ldata"}, bus.o_ld_data, 32'h0);
        chk({tag, "_illegal"}, {31'h0, bus.o_illegal}, 32'h0);
    endtask

    initial begin
        logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        logic [2:0]  st_f3 [3] = '{3'b000, 3'b001, 3'b010};
        logic [31:0] pre13;
        logic [31:0] a, wd;
        logic [2:0]  f3;
        logic        wr;
        int unsigned a_lo;

        for (int w = 0; w < DEPTH; w++)
            for (int k = 0; k < 4; k++) ref_mem[4*w + k] = init_word(w) >> (8*k);

        bus.i_valid = 1'b0; bus.i_mem_read = 1'b0; bus.i_mem_write = 1'b0;
        bus.i_funct3 = 3'b000; bus.i_addr = 32'h0; bus.i_wdata = 32'h0;

        #1 i_reset_n = 1'b0;
        #2 check_idle_outputs("reset");
        @(negedge i_clk);
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // Aligned word store then load
        check_txn(1'b1, 3'b010, 32'h10, 32'hA1B2C3D4);
        chk("sw10_addr", {21'h0, s_addr0}, 32'd4);
        chk("sw10_lanes", {28'h0, s_mt0}, 32'hF);
        chk("sw10_wdata", s_wd0, 32'hA1B2C3D4);
        chk("sw10_we", {31'h0, s_we0}, 32'h1);
        check_txn(1'b0, 3'b010, 32'h10, 32'h0);
        chk("lw10_data", s_ldd1, 32'hA1B2C3D4);

        // Byte store in top lane, signed and unsigned byte loads
        check_txn(1'b1, 3'b000, 32'h13, 32'h000000F0);
        chk("sb13_lanes", {28'h0, s_mt0}, 32'h8);
        chk("sb13_wdata", s_wd0, 32'hF0000000);
        check_txn(1'b0, 3'b000, 32'h13, 32'h0);
        chk("lb13_data", s_ldd1, 32'hFFFFFFF0);
        check_txn(1'b0, 3'b100, 32'h13, 32'h0);
        chk("lbu13_data", s_ldd1, 32'h000000F0);

        // Misaligned word store split across words 8 and 9
        check_txn(1'b1, 3'b010, 32'h21, 32'h11223344);
        chk("sw21_addr0", {21'h0, s_addr0}, 32'd8);
        chk("sw21_lanes0", {28'h0, s_mt0}, 32'hE);
        chk("sw21_wdata0", s_wd0, 32'h22334411);
        chk("sw21_addr1", {21'h0, s_addr1}, 32'd9);
        chk("sw21_lanes1", {28'h0, s_mt1}, 32'h1);
        chk("sw21_ready1", {31'h0, s_ready1}, 32'h0);
        check_txn(1'b0, 3'b010, 32'h21, 32'h0);
        chk("lw21_ldv1", {31'h0, s_ldv1}, 32'h0);
        chk("lw21_data", s_ldd2, 32'h11223344);

        // Misaligned halfword loads, positive and negative
        check_txn(1'b1, 3'b000, 32'h23, 32'h00000080);
        check_txn(1'b1, 3'b000, 32'h24, 32'h0000007F);
        check_txn(1'b0, 3'b001, 32'h23, 32'h0);
        chk("lh23_pos", s_ldd2, 32'h00007F80);
        check_txn(1'b1, 3'b000, 32'h24, 32'h00000080);
        check_txn(1'b0, 3'b001, 32'h23, 32'h0);
        chk("lh23_neg", s_ldd2, 32'hFFFF8080);
        check_txn(1'b0, 3'b101, 32'h23, 32'h0);
        chk("lhu23", s_ldd2, 32'h00008080);

        // Split at the last word wraps to word 0
        check_txn(1'b1, 3'b010, 32'h1FFE, 32'hCAFEBABE);
        chk("wrap_addr0", {21'h0, s_addr0}, 32'h7FF);
        chk("wrap_lanes0", {28'h0, s_mt0}, 32'hC);
        chk("wrap_addr1", {21'h0, s_addr1}, 32'h0);
        chk("wrap_lanes1", {28'h0, s_mt1}, 32'h3);
        check_txn(1'b0, 3'b010, 32'h1FFE, 32'h0);
        chk("wrap_load", s_ldd2, 32'hCAFEBABE);

        // Illegal funct3 for a load and a store
        check_txn(1'b0, 3'b011, 32'h40, 32'h0);
        chk("ill_ld_pulse", {31'h0, s_ill1}, 32'h1);
        chk("ill_ld_lanes", {28'h0, s_mt0}, 32'h0);
        check_txn(1'b1, 3'b100, 32'h41, 32'hDEADBEEF);
        chk("ill_st_we", {31'h0, s_we0}, 32'h0);
        chk("ill_st_ready1", {31'h0, s_ready1}, 32'h1);

        // Valid with neither read nor write is ignored
        issue(1'b0, 1'b0, 3'b010, 32'h51, 32'h0);
        chk("nop_lanes", {28'h0, s_mt0}, 32'h0);
        chk("nop_we", {31'h0, s_we0}, 32'h0);
        chk("nop_ready1", {31'h0, s_ready1}, 32'h1);
        chk("nop_illegal", {31'h0, s_ill1}, 32'h0);
        chk("nop_ldv", {31'h0, s_ldv1}, 32'h0);

        // Reset asserted while the second half of a split store is pending
        pre13 = dmem[13];
        @(negedge i_clk);
        bus.i_valid = 1'b1; bus.i_mem_write = 1'b1; bus.i_mem_read = 1'b0;
        bus.i_funct3 = 3'b010; bus.i_addr = 32'h31; bus.i_wdata = 32'h55667788;
        #1;
        chk("rsplit_lanes0", {28'h0, bus.o_mem_type}, 32'hE);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("rsplit_ready1", {31'h0, bus.o_ready}, 32'h0);
        i_reset_n = 1'b0;
        #1;
        check_idle_outputs("rsplit");
        @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk("rsplit_word13", dmem[13], pre13);
        chk("rsplit_word12", {8'h0, dmem[12][31:8]}, 32'h00667788);
        ref_mem[32'h31] = 8'h88; ref_mem[32'h32] = 8'h77; ref_mem[32'h33] = 8'h66;
        check_txn(1'b0, 3'b010, 32'h34, 32'h0);
        check_txn(1'b0, 3'b010, 32'h30, 32'h0);

        // Randomized traffic in a small window and around the wrap point
        for (int t = 0; t < 300; t++) begin
            wr   = 1'($urandom_range(0, 1));
            f3   = wr ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) f3 = 3'($urandom_range(0, 7));
            a_lo = ($urandom_range(0, 3) == 0) ? (NBYTES - 8 + $urandom_range(0, 11)) % NBYTES
                                               : $urandom_range(0, 95);
            a    = ($urandom & 32'hFFFFE000) | a_lo;
            wd   = $urandom;
            check_txn(wr, f3, a, wd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
